// File: rtl/memory_access_controller_if.sv
// Request/response and memory-port bundle for memory_access_controller.
// master: the controller's view (it initiates memory transfers).
// slave: the execute stage and data memory seen together from outside.
interface memory_access_controller_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_address;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_address;
    logic [1:0]  mem_write_mode;
    logic [7:0]  mem_write_byte;
    logic [15:0] mem_write_half_word;
    logic [31:0] mem_write_word;
    logic        mem_done;
    logic [7:0]  mem_byte_output;
    logic [15:0] mem_half_word_output;
    logic [31:0] mem_word_output;

    modport master (
        input  req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        input  mem_done, mem_byte_output, mem_half_word_output, mem_word_output,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_write_mode, mem_write_byte, mem_write_half_word, mem_write_word
    );

    modport slave (
        output req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
        output mem_done, mem_byte_output, mem_half_word_output, mem_word_output,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_write_mode, mem_write_byte, mem_write_half_word, mem_write_word
    );
endinterface

// File: rtl/memory_access_controller.sv
// Load/store initiator for the byte-addressable data memory: one request at a
// time, alignment check, write-mode/done store protocol, fixed-latency loads.
module memory_access_controller #(
    parameter int unsigned READ_LATENCY  = 2,
    parameter int unsigned WRITE_TIMEOUT = 64
) (
    input logic                         clk,
    input logic                         reset_n,
    memory_access_controller_if.master  bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        WRITE_REQ,
        WRITE_RELEASE,
        RESP
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         size_q;
    logic               unsigned_q;
    logic               resp_valid_q;
    logic [31:0]        resp_rdata_q;
    logic               resp_error_q;
    logic [31:0]        mem_address_q;
    logic [1:0]         mem_write_mode_q;
    logic [7:0]         mem_write_byte_q;
    logic [15:0]        mem_write_half_word_q;
    logic [31:0]        mem_write_word_q;

    logic               req_err_d;
    logic [31:0]        rdata_d;

    assign bus.req_ready           = reset_n && (state_q == IDLE);
    assign bus.resp_valid          = resp_valid_q;
    assign bus.resp_rdata          = resp_rdata_q;
    assign bus.resp_error          = resp_error_q;
    assign bus.mem_address         = mem_address_q;
    assign bus.mem_write_mode      = mem_write_mode_q;
    assign bus.mem_write_byte      = mem_write_byte_q;
    assign bus.mem_write_half_word = mem_write_half_word_q;
    assign bus.mem_write_word      = mem_write_word_q;

    // Illegal size or misaligned half/word access on the incoming request.
    always_comb begin
        req_err_d = 1'b0;
        case (bus.req_size)
            2'd1:    req_err_d = bus.req_address[0];
            2'd2:    req_err_d = (bus.req_address[1:0] != 2'd0);
            2'd3:    req_err_d = 1'b1;
            default: req_err_d = 1'b0;
        endcase
    end

    // Sign/zero extension of the memory read port selected by the latched size.
    always_comb begin
        rdata_d = bus.mem_word_output;
        case (size_q)
            2'd0: rdata_d = unsigned_q ? {24'd0, bus.mem_byte_output}
                                       : {{24{bus.mem_byte_output[7]}}, bus.mem_byte_output};
            2'd1: rdata_d = unsigned_q ? {16'd0, bus.mem_half_word_output}
                                       : {{16{bus.mem_half_word_output[15]}}, bus.mem_half_word_output};
            default: rdata_d = bus.mem_word_output;
        endcase
    end

    // Controller FSM with all bus outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q               <= IDLE;
            cnt_q                 <= '0;
            size_q                <= '0;
            unsigned_q            <= 1'b0;
            resp_valid_q          <= 1'b0;
            resp_rdata_q          <= '0;
            resp_error_q          <= 1'b0;
            mem_address_q         <= '0;
            mem_write_mode_q      <= '0;
            mem_write_byte_q      <= '0;
            mem_write_half_word_q <= '0;
            mem_write_word_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        size_q        <= bus.req_size;
                        unsigned_q    <= bus.req_unsigned;
                        mem_address_q <= bus.req_address;
                        if (req_err_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (bus.req_write) begin
                            state_q               <= WRITE_REQ;
                            cnt_q                 <= CNT_W'(WRITE_TIMEOUT);
                            mem_write_mode_q      <= bus.req_size + 2'd1;
                            mem_write_byte_q      <= '0;
                            mem_write_half_word_q <= '0;
                            mem_write_word_q      <= '0;
                            case (bus.req_size)
                                2'd0:    mem_write_byte_q      <= bus.req_wdata[7:0];
                                2'd1:    mem_write_half_word_q <= bus.req_wdata[15:0];
                                default: mem_write_word_q      <= bus.req_wdata;
                            endcase
                        end else begin
                            state_q <= READ_WAIT;
                            cnt_q   <= CNT_W'(READ_LATENCY);
                        end
                    end
                end

                READ_WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q      <= RESP;
                        cnt_q        <= '0;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b0;
                        resp_rdata_q <= rdata_d;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                WRITE_REQ: begin
                    // mem_done wins over a simultaneous timeout.
                    if (bus.mem_done) begin
                        state_q               <= WRITE_RELEASE;
                        cnt_q                 <= '0;
                        mem_write_mode_q      <= '0;
                        mem_write_byte_q      <= '0;
                        mem_write_half_word_q <= '0;
                        mem_write_word_q      <= '0;
                    end else if (cnt_q == CNT_W'(1)) begin
                        state_q               <= RESP;
                        cnt_q                 <= '0;
                        mem_write_mode_q      <= '0;
                        mem_write_byte_q      <= '0;
                        mem_write_half_word_q <= '0;
                        mem_write_word_q      <= '0;
                        resp_valid_q          <= 1'b1;
                        resp_error_q          <= 1'b1;
                        resp_rdata_q          <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                WRITE_RELEASE: begin
                    if (!bus.mem_done) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end

                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end

                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access_controller.sv
// Self-checking bench for memory_access_controller: table-driven requests
// against a small big-endian-lane memory model, plus a mid-store reset.
module tb_memory_access_controller;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    memory_access_controller_if bus();

    memory_access_controller #(
        .READ_LATENCY  (2),
        .WRITE_TIMEOUT (64)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- memory model ----------------
    logic [31:0] mem_w [0:255];
    bit          tie_low;
    int          wcnt;
    logic [31:0] wtmp;
    logic [31:0] rd_w;
    logic [15:0] rd_h;
    logic [7:0]  rd_b;

    always_comb begin
        rd_w = mem_w[bus.mem_address[9:2]];
        rd_h = bus.mem_address[1] ? rd_w[15:0] : rd_w[31:16];
        case (bus.mem_address[1:0])
            2'd0:    rd_b = rd_w[31:24];
            2'd1:    rd_b = rd_w[23:16];
            2'd2:    rd_b = rd_w[15:8];
            default: rd_b = rd_w[7:0];
        endcase
    end

    assign bus.mem_word_output      = rd_w;
    assign bus.mem_half_word_output = rd_h;
    assign bus.mem_byte_output      = rd_b;

    // Write completes on the second falling edge with mode up; done drops once mode returns to 0.
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.mem_done = 1'b0;
            wcnt = 0;
        end else if (bus.mem_write_mode == 2'd0) begin
            bus.mem_done = 1'b0;
            wcnt = 0;
        end else if (!tie_low && !bus.mem_done) begin
            wcnt++;
            if (wcnt >= 2) begin
                wtmp = mem_w[bus.mem_address[9:2]];
                case (bus.mem_write_mode)
                    2'd1: case (bus.mem_address[1:0])
                        2'd0:    wtmp[31:24] = bus.mem_write_byte;
                        2'd1:    wtmp[23:16] = bus.mem_write_byte;
                        2'd2:    wtmp[15:8]  = bus.mem_write_byte;
                        default: wtmp[7:0]   = bus.mem_write_byte;
                    endcase
                    2'd2: if (bus.mem_address[1]) wtmp[15:0] = bus.mem_write_half_word;
                          else                    wtmp[31:16] = bus.mem_write_half_word;
                    default: wtmp = bus.mem_write_word;
                endcase
                mem_w[bus.mem_address[9:2]] = wtmp;
                bus.mem_done = 1'b1;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          tie;
        bit          exp_err;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_mode;
        int          exp_mode_cyc;
        int          exp_lat;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic drive_req(input vec_t v);
        bus.req_write    = v.wr;
        bus.req_size     = v.size;
        bus.req_unsigned = v.uns;
        bus.req_address  = v.addr;
        bus.req_wdata    = v.wdata;
        bus.req_valid    = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          k;
        int          lat;
        int          mcyc;
        bit          got;
        bit          changed;
        logic [1:0]  seen;
        logic [7:0]  sb;
        logic [15:0] sh;
        logic [31:0] sw;
        lat = 0; mcyc = 0; got = 0; changed = 0; seen = '0; sb = '0; sh = '0; sw = '0;
        tie_low = v.tie;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_before", idx, 32'(bus.req_ready), 32'd1);
        drive_req(v);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int c = 1; c <= 200 && !got; c++) begin
            @(negedge clk);
            if (c == 1) check("ready_busy", idx, 32'(bus.req_ready), 32'd0);
            if (bus.mem_write_mode != 2'd0) begin
                if (mcyc == 0) begin
                    seen = bus.mem_write_mode;
                    sb   = bus.mem_write_byte;
                    sh   = bus.mem_write_half_word;
                    sw   = bus.mem_write_word;
                end else if (bus.mem_write_mode != seen) begin
                    changed = 1'b1;
                end
                mcyc++;
            end
            if (bus.resp_valid === 1'b1) begin
                got = 1'b1;
                lat = c;
                check("resp_error", idx, 32'(bus.resp_error), 32'(v.exp_err));
                check("resp_rdata", idx, bus.resp_rdata, v.exp_rdata);
                check("mode_at_resp", idx, 32'(bus.mem_write_mode), 32'd0);
            end
        end
        check("resp_seen", idx, 32'(got), 32'd1);
        check("latency", idx, 32'(lat), 32'(v.exp_lat));
        check("mode_value", idx, 32'(seen), 32'(v.exp_mode));
        check("mode_cycles", idx, 32'(mcyc), 32'(v.exp_mode_cyc));
        check("mode_stable", idx, 32'(changed), 32'd0);
        if (v.exp_mode != 2'd0) begin
            check("wr_byte", idx, 32'(sb), (v.exp_mode == 2'd1) ? {24'd0, v.wdata[7:0]} : 32'd0);
            check("wr_half", idx, 32'(sh), (v.exp_mode == 2'd2) ? {16'd0, v.wdata[15:0]} : 32'd0);
            check("wr_word", idx, sw, (v.exp_mode == 2'd3) ? v.wdata : 32'd0);
        end
        @(negedge clk);
        check("ready_after", idx, 32'(bus.req_ready), 32'd1);
        check("resp_pulse", idx, 32'(bus.resp_valid), 32'd0);
        tie_low = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no end, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  seen_resp;
        // wr size uns addr wdata tie | err rdata mode mode_cyc lat
        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        2'd3, 2,  4};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 2'd0, 0,  3};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h041, 32'hFFFFFF80, 1'b0, 1'b0, 32'h0,        2'd1, 2,  4};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h041, 32'h0,        1'b0, 1'b0, 32'hFFFFFF80, 2'd0, 0,  3};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h041, 32'h0,        1'b0, 1'b0, 32'h00000080, 2'd0, 0,  3};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h1234BEEF, 1'b0, 1'b0, 32'h0,        2'd2, 2,  4};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h202, 32'h0,        1'b0, 1'b0, 32'hFFFFBEEF, 2'd0, 0,  3};
        vecs[7]  = '{1'b0, 2'd1, 1'b1, 32'h202, 32'h0,        1'b0, 1'b0, 32'h0000BEEF, 2'd0, 0,  3};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 32'h203, 32'h0,        1'b0, 1'b1, 32'h0,        2'd0, 0,  1};
        vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h102, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0,        2'd0, 0,  1};
        vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h000, 32'h0,        1'b0, 1'b1, 32'h0,        2'd0, 0,  1};
        vecs[11] = '{1'b0, 2'd2, 1'b1, 32'h100, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 2'd0, 0,  3};
        vecs[12] = '{1'b1, 2'd2, 1'b0, 32'h010, 32'h12345678, 1'b1, 1'b1, 32'h0,        2'd3, 64, 65};

        for (int i = 0; i < 256; i++) mem_w[i] = 32'd0;
        tie_low          = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_address  = 32'd0;
        bus.req_wdata    = 32'd0;
        reset_n          = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ready", -1, 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", -1, 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", -1, bus.resp_rdata, 32'd0);
        check("rst_resp_error", -1, 32'(bus.resp_error), 32'd0);
        check("rst_mode", -1, 32'(bus.mem_write_mode), 32'd0);
        check("rst_address", -1, bus.mem_address, 32'd0);
        check("rst_wr_byte", -1, 32'(bus.mem_write_byte), 32'd0);
        check("rst_wr_half", -1, 32'(bus.mem_write_half_word), 32'd0);
        check("rst_wr_word", -1, bus.mem_write_word, 32'd0);
        reset_n = 1'b1;
        #1 check("rst_release_ready", -1, 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Reset pulsed while a store waits for mem_done.
        tie_low = 1'b1;
        drive_req('{1'b1, 2'd2, 1'b0, 32'h020, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 2'd3, 0, 0});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_store_mode", 100, 32'(bus.mem_write_mode), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("async_mode_drop", 100, 32'(bus.mem_write_mode), 32'd0);
        check("async_ready_low", 100, 32'(bus.req_ready), 32'd0);
        check("async_no_resp", 100, 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1 check("release_ready", 100, 32'(bus.req_ready), 32'd1);
        seen_resp = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) seen_resp++;
        end
        check("aborted_no_resp", 100, 32'(seen_resp), 32'd0);
        check("aborted_mode", 100, 32'(bus.mem_write_mode), 32'd0);
        check("aborted_ready", 100, 32'(bus.req_ready), 32'd1);
        tie_low = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
